// File: rtl/uart_memory_loader.sv
// UART (8N1, LSB first) boot loader: assembles little-endian words and writes them to memory_unit.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit checksum byte after the data words.
module uart_memory_loader #(
    parameter int WTIME      = 10,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  UART_RX,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ADDR_WIDTH-1:0] word_count,
    output logic                  rw_flag,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] write_memory_value,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_error,
    output logic                  checksum_error
);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int BIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TW = $clog2(WTIME);
    localparam logic [TW-1:0] T_FULL = TW'(WTIME - 1);
    localparam logic [TW-1:0] T_HALF = TW'(WTIME / 2 - 1);
    localparam logic [BIDX_W-1:0] LAST_LANE = BIDX_W'(BYTES_PER_WORD - 1);
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, WAIT_START, START_BIT, DATA_BITS, STOP_BIT, WRITE, DONE
    } state_t;

    state_t state, state_next;

    logic                  rx_meta, rx_sync, armed;
    logic [TW-1:0]         timer;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift_reg;
    logic [BIDX_W-1:0]     byte_idx;
    logic [DATA_WIDTH-1:0] word_buf, new_word;
    logic [ADDR_WIDTH-1:0] count_reg, words_written;
    logic                  half_tick, bit_tick, last_word, checksum_phase;

    assign half_tick      = (timer == T_HALF);
    assign bit_tick       = (timer == T_FULL);
    assign last_word      = ((words_written + ADDR_WIDTH'(1)) == count_reg);
    assign checksum_phase = CK_EN && (words_written == count_reg);

    always_comb begin
        new_word = word_buf;
        new_word[int'(byte_idx) * 8 +: 8] = shift_reg;
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start) state_next = (word_count == '0 && !CK_EN) ? DONE : WAIT_START;
            WAIT_START: if (armed && !rx_sync) state_next = START_BIT;
            START_BIT:  if (half_tick) state_next = rx_sync ? WAIT_START : DATA_BITS;
            DATA_BITS:  if (bit_tick && bit_cnt == 3'd7) state_next = STOP_BIT;
            STOP_BIT: begin
                if (bit_tick) begin
                    if (!rx_sync)                   state_next = WAIT_START;
                    else if (checksum_phase)        state_next = DONE;
                    else if (byte_idx == LAST_LANE) state_next = WRITE;
                    else                            state_next = WAIT_START;
                end
            end
            WRITE:      state_next = (last_word && !CK_EN) ? DONE : WAIT_START;
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        rw_flag = (state == WRITE);
        done    = (state == DONE);
        busy    = (state != IDLE);
    end

    // armed means the line was seen high since the last start; a low line then counts as a start edge
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            rx_meta            <= 1'b1;
            rx_sync            <= 1'b1;
            armed              <= 1'b0;
            timer              <= '0;
            bit_cnt            <= '0;
            shift_reg          <= '0;
            byte_idx           <= '0;
            word_buf           <= '0;
            count_reg          <= '0;
            words_written      <= '0;
            address            <= '0;
            write_memory_value <= '0;
            frame_error        <= 1'b0;
        end else begin
            rx_meta <= UART_RX;
            rx_sync <= rx_meta;
            if (state == STOP_BIT && bit_tick)       armed <= rx_sync;
            else if (state == WAIT_START && !rx_sync) armed <= 1'b0;
            else if (rx_sync)                         armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        address       <= base_address;
                        count_reg     <= word_count;
                        words_written <= '0;
                        byte_idx      <= '0;
                        frame_error   <= 1'b0;
                    end
                end
                WAIT_START: begin
                    timer   <= '0;
                    bit_cnt <= '0;
                end
                START_BIT: timer <= half_tick ? '0 : timer + TW'(1);
                DATA_BITS: begin
                    if (bit_tick) begin
                        timer     <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP_BIT: begin
                    if (bit_tick) begin
                        timer <= '0;
                        if (!rx_sync) begin
                            frame_error <= 1'b1;
                        end else if (!checksum_phase) begin
                            word_buf <= new_word;
                            if (byte_idx == LAST_LANE) write_memory_value <= new_word;
                            else                       byte_idx <= byte_idx + BIDX_W'(1);
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WRITE: begin
                    address       <= address + ADDR_WIDTH'(1);
                    words_written <= words_written + ADDR_WIDTH'(1);
                    byte_idx      <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            sum            <= '0;
            checksum_error <= 1'b0;
        end else if (state == IDLE && start) begin
            sum            <= '0;
            checksum_error <= 1'b0;
        end else if (state == STOP_BIT && bit_tick && rx_sync) begin
            if (checksum_phase) begin
                if ((sum + shift_reg) != 8'd0) checksum_error <= 1'b1;
            end else begin
                sum <= sum + shift_reg;
            end
        end
    end
`else
    assign checksum_error = 1'b0;
`endif

endmodule
